buffer_fifo: RTL and testbench
==============================

Name: buffer_fifo

Overview:
- Parametrised synchronous FIFO built around a dual-port buffer memory, with one write port and one read port.
- Uses a valid/ready handshake on both sides, a registered show-ahead output stage, occupancy count, programmable almost-full/almost-empty flags, synchronous flush and sticky overflow/underflow error flags.
- Sits between PE/bus producers and consumers wherever the plain addressed buffer needs flow control instead of external pointer management.

Parameters:
- addrLen, 6, RAM address width; RAM depth memSize = 1 << addrLen.
- dataLen, 32, data word width.
- ram_type, "distributed", ram_style attribute on the storage array ("distributed" or "block").
- almostFullThr, memSize-2, almost_full asserts when count >= almostFullThr.
- almostEmptyThr, 2, almost_empty asserts when count <= almostEmptyThr.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of all contents.
- in_valid  input  1  producer presents data_in.
- in_ready  output  1  FIFO can accept a word.
- data_in  input  dataLen  write data.
- out_valid  output  1  data_out holds the head word.
- out_ready  input  1  consumer takes the head word.
- data_out  output  dataLen  head word, registered.
- count  output  addrLen+1  words held (RAM plus output register), 0..memSize.
- almost_full  output  1  count >= almostFullThr.
- almost_empty  output  1  count <= almostEmptyThr.
- overflow  output  1  sticky: in_valid seen while in_ready=0.
- underflow  output  1  sticky: out_ready seen while out_valid=0.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values (reset=0): wr_ptr=0, rd_ptr=0, count=0, out_valid=0, data_out=0, in_ready=1, almost_full=0, almost_empty=1, overflow=0, underflow=0. RAM contents are not reset.
- Push occurs when in_valid && in_ready at an edge. mem[wr_ptr] <= data_in; wr_ptr increments modulo memSize.
- Pop occurs when out_valid && out_ready at an edge.
- in_ready = (count < memSize), combinational from count. It does not depend on out_ready; there is no same-cycle pass-through when full.
- Prefetch: at an edge where the RAM holds unread words (wr_ptr != rd_ptr, or ptrs equal with RAM full) and (out_valid==0 or pop), data_out <= mem[rd_ptr], rd_ptr increments, out_valid <= 1.
- At a pop with no prefetch possible, out_valid <= 0 and data_out holds its last value.
- RAM read is synchronous. A word pushed at edge N cannot be prefetched before edge N+1, so the earliest out_valid=1 after an empty-FIFO push is after edge N+1. This is 2-cycle first-word latency; there is no write-to-read bypass.
- Back-to-back pops stream one word per cycle while data is available.
- count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop. Width addrLen+1 so memSize is representable.
- RAM-full tracking uses an extra wrap bit on each pointer. Total capacity is exactly memSize words; the output register word counts toward it.
- Simultaneous push and pop when full is impossible, since in_ready=0. A pop frees a slot and in_ready rises the next cycle.
- Simultaneous push and pop when count==1 (head in output register): the head pops, and the new word reaches data_out at the following edge. out_valid=0 for exactly one cycle.
- almost_full and almost_empty are combinational from count.
- flush=1 at an edge: pointers, count and out_valid clear as on reset. A push or pop in the same cycle is discarded. Error flags are not cleared by flush.
- overflow and underflow set on the violating edge and clear only on reset. A violating attempt does not modify state.
- Reset asserted mid-stream clears all state immediately, without waiting for an edge. Stale RAM words are never presented after reset.

Decomposition:
- Shared package holds helper constants only: a clog2 function for parameter checks, plus the default thresholds.
- The storage array is the existing dual-port buffer module (synchronous read, ram_type passed through), instantiated as the single sub-module.
- Pointer, count and output-stage logic stay in buffer_fifo.

Test Plan:
- Reset then single push 0xA5A5_0001 at edge 1 -> out_valid=0 after edge 1, out_valid=1 with data_out=0xA5A5_0001 after edge 2, count=1; pop -> count=0, out_valid=0, almost_empty=1.
- addrLen=3: push 8 words 0..7 with out_ready=0 -> in_ready=0 after the 8th, count=8, almost_full=1 from count 6; a 9th in_valid sets overflow=1 and count stays 8.
- Full FIFO, out_ready=1 continuously -> data_out yields 0..7 on consecutive cycles; in_ready=1 one cycle after the first pop; count reaches 0.
- Continuous push and pop with in_valid=out_ready=1 over 100 words -> data_out order matches input order; count stays at or below 2 after the startup transient; no error flags.
- out_ready=1 on an empty FIFO -> underflow=1, remains set after a later flush, and clears only on reset=0.
- Push 5 words, then flush=1 together with a push -> count=0, out_valid=0 after that edge; the next push of 0x42 appears as data_out=0x42 two edges later.

Source files
------------

// File: rtl/buffer_fifo_pkg.sv
// buffer_fifo shared constants
// default sizes, thresholds and a clog2 helper
package buffer_fifo_pkg;

  localparam int DEF_ADDR_LEN = 6;
  localparam int DEF_DATA_LEN = 32;
  localparam int DEF_AE_THR   = 2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/buffer_fifo_mem.sv
// dual-port buffer memory
// one write port, one synchronous read port
module buffer_fifo_mem #(
  parameter int AW = 6,
  parameter int DW = 32,
  parameter     ram_type = "distributed"
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  (* ram_style = ram_type *)
  logic [DW-1:0] r_mem [0:(1<<AW)-1];
  logic [DW-1:0] r_q;

  // storage write; contents are never reset
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // registered read; the register is the head word
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_q <= '0;
    else if (i_re) r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/buffer_fifo.sv
// buffer_fifo: valid/ready FIFO over the buffer memory
// show-ahead output register, count, flags, flush
module buffer_fifo
  import buffer_fifo_pkg::*;
#(
  parameter int addrLen = DEF_ADDR_LEN,
  parameter int dataLen = DEF_DATA_LEN,
  parameter     ram_type = "distributed",
  parameter int almostFullThr = (1 << addrLen) - 2,
  parameter int almostEmptyThr = DEF_AE_THR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [dataLen-1:0] data_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [dataLen-1:0] data_out,
  output logic [addrLen:0]   count,
  output logic               almost_full,
  output logic               almost_empty,
  output logic               overflow,
  output logic               underflow
);

  localparam int memSize = 1 << addrLen;
  localparam int AW = clog2(memSize);

  localparam logic [AW:0] MEM_C = (AW+1)'(memSize);
  localparam logic [AW:0] AF_C  = (AW+1)'(almostFullThr);
  localparam logic [AW:0] AE_C  = (AW+1)'(almostEmptyThr);
  localparam logic [AW:0] ONE_C = (AW+1)'(1);

  logic [AW:0]        r_wr_ptr;
  logic [AW:0]        r_rd_ptr;
  logic [AW:0]        r_count;
  logic               r_out_valid;
  logic               r_ovf;
  logic               r_unf;

  logic               w_in_ready;
  logic               w_ram_ne;
  logic               w_push;
  logic               w_pop;
  logic               w_pref;
  logic [dataLen-1:0] w_rdata;

  assign w_in_ready = r_count < MEM_C;
  // wrap bit makes unequal pointers mean "RAM holds words"
  assign w_ram_ne   = r_wr_ptr != r_rd_ptr;
  assign w_push = in_valid & w_in_ready & ~flush;
  assign w_pop  = r_out_valid & out_ready & ~flush;
  assign w_pref = w_ram_ne & (~r_out_valid | w_pop)
                & ~flush;

  buffer_fifo_mem #(
    .AW       (AW),
    .DW       (dataLen),
    .ram_type (ram_type)
  ) u_mem (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (data_in),
    .i_re    (w_pref),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_rdata)
  );

  // pointers, occupancy and output-stage valid
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + ONE_C;
      if (w_pref) r_rd_ptr <= r_rd_ptr + ONE_C;
      if (w_pref)     r_out_valid <= 1'b1;
      else if (w_pop) r_out_valid <= 1'b0;
      if (w_push && !w_pop)
        r_count <= r_count + ONE_C;
      else if (w_pop && !w_push)
        r_count <= r_count - ONE_C;
    end
  end

  // sticky protocol-violation flags, cleared by reset only
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (in_valid && !w_in_ready) r_ovf <= 1'b1;
      if (out_ready && !r_out_valid) r_unf <= 1'b1;
    end
  end

  assign in_ready     = w_in_ready;
  assign out_valid    = r_out_valid;
  assign data_out     = w_rdata;
  assign count        = r_count;
  assign almost_full  = r_count >= AF_C;
  assign almost_empty = r_count <= AE_C;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

endmodule

// File: tb/tb_buffer_fifo.sv
// buffer_fifo bench
// scoreboard queue of pushed words, checked on pop
module tb_buffer_fifo;

  localparam int AL = 3;
  localparam int DL = 32;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DL-1:0] data_in;
  logic          out_valid;
  logic          out_ready;
  logic [DL-1:0] data_out;
  logic [AL:0]   count;
  logic          almost_full;
  logic          almost_empty;
  logic          overflow;
  logic          underflow;

  int n_checks;
  int n_fail;
  logic [DL-1:0] exp_q[$];
  bit last_push;

  buffer_fifo #(
    .addrLen (AL),
    .dataLen (DL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .data_in      (data_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .data_out     (data_out),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // one clock: note handshakes before the edge,
  // update the scoreboard after it
  task automatic cycle();
    bit acc;
    bit pp;
    bit fl;
    logic [DL-1:0] dout;
    logic [DL-1:0] din;
    acc  = in_valid && in_ready && !flush;
    pp   = out_valid && out_ready && !flush;
    fl   = flush;
    dout = data_out;
    din  = data_in;
    @(posedge clk);
    #1;
    if (fl) exp_q.delete();
    if (pp) begin
      chk("sb_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0)
        chk("pop_data", dout, exp_q.pop_front());
    end
    if (acc) exp_q.push_back(din);
    last_push = acc;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    #2;
    reset = 1'b0;
    #2;
    exp_q.delete();
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent;
    int cyc;
    int maxc;
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data_in   = '0;
    #12;
    chk("rst_count", count, 0);
    chk("rst_ovalid", out_valid, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_iready", in_ready, 1);
    chk("rst_afull", almost_full, 0);
    chk("rst_aempty", almost_empty, 1);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // single word, 2-cycle first-word latency
    in_valid = 1'b1;
    data_in  = 32'hA5A5_0001;
    cycle();
    in_valid = 1'b0;
    chk("lat_e1_valid", out_valid, 0);
    cycle();
    chk("lat_e2_valid", out_valid, 1);
    chk("lat_e2_data", data_out, 32'hA5A5_0001);
    chk("lat_e2_count", count, 1);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    chk("pop1_count", count, 0);
    chk("pop1_valid", out_valid, 0);
    chk("pop1_aempty", almost_empty, 1);

    // fill to capacity
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      data_in  = i;
      cycle();
      chk("fill_count", count, exp_q.size());
      chk("fill_afull", almost_full,
          exp_q.size() >= 6);
      chk("fill_aempty", almost_empty,
          exp_q.size() <= 2);
    end
    chk("full_iready", in_ready, 0);
    chk("full_count", count, 8);
    data_in = 32'hDEAD;
    cycle();
    in_valid = 1'b0;
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 8);

    // drain at full rate
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_valid", out_valid, 1);
      cycle();
      if (i == 0) chk("drain_iready", in_ready, 1);
    end
    out_ready = 1'b0;
    chk("drain_count", count, 0);
    chk("drain_ovalid", out_valid, 0);

    do_reset();
    chk("rst2_ovf", overflow, 0);

    // continuous streaming
    sent = 0;
    cyc  = 0;
    maxc = 0;
    while ((sent < 100 || exp_q.size() != 0)
           && cyc < 400) begin
      in_valid  = sent < 100;
      data_in   = $urandom;
      out_ready = out_valid;
      cycle();
      if (last_push) sent++;
      cyc++;
      if (cyc > 3 && int'(count) > maxc)
        maxc = int'(count);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("stream_done", cyc < 400, 1);
    chk("stream_sent", sent, 100);
    chk("stream_maxcnt_le2", maxc <= 2, 1);
    chk("stream_count", count, 0);
    chk("stream_ovf", overflow, 0);
    chk("stream_unf", underflow, 0);

    // flush with a concurrent push
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      data_in  = 32'h100 + i;
      cycle();
    end
    chk("pre_flush_count", count, 5);
    flush   = 1'b1;
    data_in = 32'h99;
    cycle();
    flush = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_valid", out_valid, 0);
    data_in = 32'h42;
    cycle();
    in_valid = 1'b0;
    chk("fl_e1_valid", out_valid, 0);
    cycle();
    chk("fl_e2_valid", out_valid, 1);
    chk("fl_e2_data", data_out, 32'h42);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    chk("fl_pop_count", count, 0);

    // asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      data_in  = 32'h300 + i;
      cycle();
    end
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_iready", in_ready, 1);
    exp_q.delete();
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    cycle();
    chk("arst_no_stale", out_valid, 0);

    // underflow is sticky across flush
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    chk("unf_set", underflow, 1);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("unf_after_flush", underflow, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("unf_rst", underflow, 0);
    reset = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d",
             n_checks, n_fail);
    $finish;
  end

endmodule
